// File: rtl/ram_fifo_pkg.sv
// ============================================================================
// Module   : ram_fifo_pkg
// Purpose  : Shared types, default widths and the depth sanity function for
//            the RAM-backed FIFO controller.
// Contents : op_t      - RAM port operation (idle / write / read)
//            DEF_*     - default parameter values
//            depth_ok  - true when MEMORY_SIZE == 2**ADDR_SIZE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_fifo_pkg;

  localparam int DEF_ADDR_SIZE   = 10;
  localparam int DEF_WORD_SIZE   = 8;
  localparam int DEF_MEMORY_SIZE = 1024;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } op_t;

  // Pointers wrap by natural overflow, so the depth must fill the address space.
  function automatic bit depth_ok(input int addr_size, input int memory_size);
    return (memory_size == (1 << addr_size));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_fifo_ptr.sv
// ============================================================================
// Module   : ram_fifo_ptr
// Purpose  : Write/read pointers, RAM occupancy count and full/empty flags.
// Ports    : clk, rst_n      - clock, async active-low reset
//            push, pop       - one write / one read issued at this edge
//            wptr, rptr      - next RAM write / read address
//            count           - words held in RAM (0..MEMORY_SIZE)
//            full, empty     - count == MEMORY_SIZE / count == 0
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_ptr
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  output logic [ADDR_SIZE-1:0] wptr,
  output logic [ADDR_SIZE-1:0] rptr,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [ADDR_SIZE:0]   C_DEPTH   = (ADDR_SIZE+1)'(MEMORY_SIZE);
  localparam logic [ADDR_SIZE-1:0] C_PTR_ONE = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE:0]   C_CNT_ONE = (ADDR_SIZE+1)'(1);

  logic [ADDR_SIZE-1:0] r_wptr;
  logic [ADDR_SIZE-1:0] r_rptr;
  logic [ADDR_SIZE:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + C_PTR_ONE;
      if (pop)  r_rptr <= r_rptr + C_PTR_ONE;
      case ({push, pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign wptr  = r_wptr;
  assign rptr  = r_rptr;
  assign count = r_count;
  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
// Module   : ram_fifo_ctrl
// Purpose  : FIFO controller in front of a single-port, asynchronous-read RAM.
//            Converts a valid/ready input stream into RAM writes and RAM reads
//            into a valid/ready output stream, one RAM operation per clock,
//            reads having priority. All RAM-side outputs come straight from
//            flops.
// Ports    : clk, rst_n                   - clock, async active-low reset
//            in_valid/in_ready/in_data    - input stream
//            out_valid/out_ready/out_data - output stream
//            level                        - words held (RAM + read + out reg)
//            ram_addr/ram_din/ram_wr/ram_cs/ram_dout - RAM port
// Options  : RAM_FIFO_BYPASS_EN - when defined, a word arriving at an empty
//            FIFO with a free output register skips the RAM entirely.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [ADDR_SIZE:0]   level,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_din,
  output logic                 ram_wr,
  output logic                 ram_cs,
  input  logic [WORD_SIZE-1:0] ram_dout
);

  generate
    if (!depth_ok(ADDR_SIZE, MEMORY_SIZE)) begin : g_depth_check
      $error("ram_fifo_ctrl: MEMORY_SIZE must equal 2**ADDR_SIZE");
    end
  endgenerate

  logic [ADDR_SIZE-1:0] w_wptr;
  logic [ADDR_SIZE-1:0] w_rptr;
  logic [ADDR_SIZE:0]   w_count;
  logic                 w_full;
  logic                 w_empty;

  op_t                  r_op;
  op_t                  w_op_nxt;
  logic                 r_ram_cs;
  logic                 r_ram_wr;
  logic [ADDR_SIZE-1:0] r_ram_addr;
  logic [WORD_SIZE-1:0] r_ram_din;
  logic                 r_out_valid;
  logic [WORD_SIZE-1:0] r_out_data;

  logic                 w_can_load;
  logic                 w_rd_grant;
  logic                 w_in_ready;
  logic                 w_bypass;
  logic                 w_wr_accept;

  // The output register can take a new word only if no capture is already
  // pending (op==RD) and it is empty or being drained at this edge.
  assign w_can_load = (r_op != OP_RD) && (!r_out_valid || out_ready);
  assign w_rd_grant = !w_empty && w_can_load;
  assign w_in_ready = !w_full && !w_rd_grant;

`ifdef RAM_FIFO_BYPASS_EN
  assign w_bypass = w_empty && w_can_load && in_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word is accepted but never written to the RAM.
  assign w_wr_accept = in_valid && w_in_ready && !w_bypass;

  ram_fifo_ptr #(
    .ADDR_SIZE   (ADDR_SIZE),
    .MEMORY_SIZE (MEMORY_SIZE)
  ) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_wr_accept),
    .pop   (w_rd_grant),
    .wptr  (w_wptr),
    .rptr  (w_rptr),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_op_nxt = OP_IDLE;
    if (w_rd_grant) begin
      w_op_nxt = OP_RD;
    end else if (w_wr_accept) begin
      w_op_nxt = OP_WR;
    end
  end

  // ram_cs/ram_wr are separate flops rather than a decode of r_op, so they
  // cannot glitch on an op-to-op transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_IDLE;
      r_ram_cs   <= 1'b0;
      r_ram_wr   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_op     <= w_op_nxt;
      r_ram_cs <= (w_op_nxt != OP_IDLE);
      r_ram_wr <= (w_op_nxt == OP_WR);
      if (w_rd_grant) begin
        r_ram_addr <= w_rptr;
      end else if (w_wr_accept) begin
        r_ram_addr <= w_wptr;
        r_ram_din  <= in_data;
      end
    end
  end

  // Output register: capture the RAM read that ran during this cycle, or the
  // bypassed input word; otherwise drop the word once it has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (r_op == OP_RD) begin
      r_out_valid <= 1'b1;
      r_out_data  <= ram_dout;
    end else if (w_bypass) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign ram_wr    = r_ram_wr;
  assign ram_cs    = r_ram_cs;
  assign level     = w_count
                   + (ADDR_SIZE+1)'(r_op == OP_RD)
                   + (ADDR_SIZE+1)'(r_out_valid);

endmodule

`default_nettype wire
